// File: rtl/simon_pkg.sv
// simon_pkg: definitions shared by the Simon control FSM and the Simon datapath.
//   state_t      - 3-bit control state encoding (codes 5..7 are unused)
//   MODE_*       - mode_leds / phase codes
//   SEL_*        - read-address mux select codes
//   MAX_ROUNDS_DEFAULT - rounds that fill the pattern memory
package simon_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR    = 3'd0,
        ST_INPUT    = 3'd1,
        ST_PLAYBACK = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [2:0] MODE_CLEAR  = 3'b000;
    localparam logic [2:0] MODE_INPUT  = 3'b001;
    localparam logic [2:0] MODE_PLAY   = 3'b010;
    localparam logic [2:0] MODE_REPEAT = 3'b100;
    localparam logic [2:0] MODE_DONE   = 3'b111;

    localparam logic [1:0] SEL_PLAY   = 2'b00;
    localparam logic [1:0] SEL_REPEAT = 2'b01;
    localparam logic [1:0] SEL_DONE   = 2'b10;

    localparam int MAX_ROUNDS_DEFAULT = 64;

endpackage

// File: rtl/simon_control.sv
// simon_control: control FSM for the Simon game. Steps the datapath through
// CLEAR -> INPUT -> PLAYBACK -> REPEAT -> (INPUT | DONE), counts completed
// rounds and flags a win when the pattern memory has been filled.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   is_legal          - switch pattern is legal for the level
//   play_eq_count     - playback finished
//   repeat_eq_play    - repeat finished
//   input_eq_pattern  - switches match the memory read data
//   select[1:0]       - read-address mux select
//   mode_leds[2:0]    - phase code / mode LEDs (also the visible FSM state)
//   clrcount          - clear datapath count register and pattern LEDs
//   w_en              - pattern memory write enable (Mealy on is_legal)
//   round[6:0]        - rounds completed, saturating at MAX_ROUNDS
//   win               - set on the winning REPEAT exit, held until reset
module simon_control
    import simon_pkg::*;
#(
    parameter int MAX_ROUNDS = MAX_ROUNDS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       is_legal,
    input  logic       play_eq_count,
    input  logic       repeat_eq_play,
    input  logic       input_eq_pattern,
    output logic [1:0] select,
    output logic [2:0] mode_leds,
    output logic       clrcount,
    output logic       w_en,
    output logic [6:0] round,
    output logic       win
);

    localparam logic [6:0] ROUND_CAP  = 7'(MAX_ROUNDS);
    localparam logic [6:0] LAST_ROUND = 7'(MAX_ROUNDS - 1);

    state_t     state_q, state_d;
    logic [6:0] round_q;
    logic       win_q;
    logic       round_inc;
    logic       win_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            round_q <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (round_inc && (round_q != ROUND_CAP)) begin
                round_q <= round_q + 7'd1;
            end
            if (win_set) begin
                win_q <= 1'b1;
            end
        end
    end

    // Everything except w_en depends on state_q alone; w_en is the one
    // combinational path so the write lands on the INPUT -> PLAYBACK edge.
    always_comb begin
        state_d   = state_q;
        select    = SEL_PLAY;
        mode_leds = MODE_CLEAR;
        clrcount  = 1'b0;
        w_en      = 1'b0;
        round_inc = 1'b0;
        win_set   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clrcount = 1'b1;
                state_d  = ST_INPUT;
            end
            ST_INPUT: begin
                mode_leds = MODE_INPUT;
                w_en      = is_legal;
                if (is_legal) begin
                    state_d = ST_PLAYBACK;
                end
            end
            ST_PLAYBACK: begin
                mode_leds = MODE_PLAY;
                if (play_eq_count) begin
                    state_d = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                mode_leds = MODE_REPEAT;
                select    = SEL_REPEAT;
                // A mismatch ends the game before repeat completion is considered.
                if (!input_eq_pattern) begin
                    state_d = ST_DONE;
                end else if (repeat_eq_play) begin
                    round_inc = 1'b1;
                    if (round_q == LAST_ROUND) begin
                        win_set = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_INPUT;
                    end
                end
            end
            ST_DONE: begin
                mode_leds = MODE_DONE;
                select    = SEL_DONE;
            end
            default: begin
                // Unused encodings fall back to CLEAR on the next edge.
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign round = round_q;
    assign win   = win_q;

endmodule

// File: doc/simon_control.md
# simon_control

Control FSM for the Simon game. It sequences the Simon datapath through its four phases: input, playback, repeat and done. It drives the datapath control signals (`select`, `mode_leds`, `clrcount`, `w_en`) from the datapath status flags, tracks the round number, and flags a win when the pattern memory is exhausted. It sits beside the Simon datapath in the Simon top level and shares its clock.

## Interface
- `MAX_ROUNDS`, default 64: number of rounds that fills pattern memory; completing this round is a win.
- `clk`  in  1  system clock; one FSM step per rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `is_legal`  in  1  datapath: current switch pattern is legal for the selected level.
- `play_eq_count`  in  1  datapath: playback index has passed the stored count (playback finished).
- `repeat_eq_play`  in  1  datapath: repeat index equals playback length (repeat finished).
- `input_eq_pattern`  in  1  datapath: switch pattern equals memory read data.
- `select`  out  2  read-address mux select: 00 playback, 01 repeat, 10 done.
- `mode_leds`  out  3  phase code and mode LEDs: 001 INPUT, 010 PLAYBACK, 100 REPEAT, 111 DONE, 000 CLEAR.
- `clrcount`  out  1  clears the datapath count register and pattern LEDs.
- `w_en`  out  1  pattern memory write enable.
- `round`  out  7  rounds completed successfully, 0..`MAX_ROUNDS`.
- `win`  out  1  high in DONE when all `MAX_ROUNDS` rounds were completed.

## Operation
- States:
  - CLEAR: `clrcount=1`, `mode_leds=000`, `select=00`, `w_en=0`.
  - INPUT: `mode_leds=001`, `select=00`, `w_en=is_legal` (Mealy).
  - PLAYBACK: `mode_leds=010`, `select=00`.
  - REPEAT: `mode_leds=100`, `select=01`.
  - DONE: `mode_leds=111`, `select=10`.
- `clrcount=0` and `w_en=0` in every state other than the ones listed above.
- Transitions:
  - CLEAR -> INPUT unconditionally.
  - INPUT -> PLAYBACK if `is_legal`; otherwise stay in INPUT, with no write.
  - PLAYBACK -> REPEAT if `play_eq_count`; otherwise stay.
  - REPEAT:
    - to DONE if `!input_eq_pattern` (mismatch wins over all other conditions);
    - else to DONE with `win` set if `repeat_eq_play` and `round==MAX_ROUNDS-1`;
    - else to INPUT if `repeat_eq_play`;
    - else stay.
  - DONE: absorbing; only `rst` leaves it.
- `round` increments by 1 on every successful REPEAT exit (both the INPUT and the win exit). It saturates at `MAX_ROUNDS` and never wraps.
- `win` is set only on the win transition and held until reset.
- All outputs except `w_en` are decoded from the state register only, so they are glitch-free relative to `clk`.

## Timing
- Reset: `rst` sampled high at an edge forces state=CLEAR, `round=0`, `win=0`. This applies from any state, including mid-playback or mid-repeat.
- Outputs while in CLEAR: `clrcount=1`, `mode_leds=000`, `select=00`, `w_en=0`.
- Holding `rst` keeps the block in CLEAR. INPUT is entered on the first edge with `rst=0`.
- One state transition per edge; the status inputs are sampled at that edge.
- Latency: zero cycles from `is_legal` to `w_en`, which is combinational in INPUT. One cycle from a flag to the new state and its outputs.
- The memory write occurs at the same edge that moves INPUT -> PLAYBACK.
- Simultaneous `!input_eq_pattern` and `repeat_eq_play` in REPEAT: go to DONE, `win=0`, `round` unchanged.
- Flags that are irrelevant to the current state are ignored.
- Unknown or illegal state encodings recover to CLEAR on the next edge.

## Structure
- Shared package `simon_pkg` holds:
  - the state encoding localparams (3-bit);
  - the `mode_leds` codes (`MODE_INPUT`, `MODE_PLAY`, `MODE_REPEAT`, `MODE_DONE`, `MODE_CLEAR`);
  - the `select` codes (`SEL_PLAY`, `SEL_REPEAT`, `SEL_DONE`);
  - the `MAX_ROUNDS` default.
- The datapath imports the same package.
- Single module: one state register, next-state logic, output decode, and the round counter with win flag. No sub-module is warranted.

## Test plan
- Reset then idle: `rst=1` for 2 cycles, then 0 -> one cycle with `mode_leds=000`, `clrcount=1`, then `mode_leds=001`, `round=0`, `win=0`.
- Illegal input: in INPUT with `is_legal=0` for 5 cycles -> `w_en=0`, state stays INPUT. Then `is_legal=1` -> `w_en=1` in that cycle, `mode_leds=010` next cycle.
- Full round: legal input, `play_eq_count` after 3 cycles, then REPEAT with `input_eq_pattern=1` and `repeat_eq_play=1` on the 2nd cycle -> sequence 001, 010 x3, 100 x2, 001; `round=1`; `select` follows 00/00/01/00.
- Mismatch: in REPEAT, `input_eq_pattern=0` together with `repeat_eq_play=1` -> DONE (`mode_leds=111`, `select=10`), `win=0`, `round` unchanged. Stays in DONE for 10 cycles despite any flag activity.
- Win: `MAX_ROUNDS=2`, two successful rounds -> after the second REPEAT exit `mode_leds=111`, `win=1`, `round=2`.
- Mid-operation reset: `rst=1` during PLAYBACK with `round=3` -> next edge CLEAR, `round=0`, `clrcount=1`, then INPUT.
